// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 max pool over a raster-ordered pixel stream, with frame markers.
// Latency: one cycle from the bottom-right beat of a window to pool_valid_o.
// Backpressure: none; the input is consumed every valid cycle and outputs are not stalled.
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   cnn_valid_i, cnn_data_i   input pixel stream, row-major, one pixel per valid cycle
//   pool_valid_o, pool_data_o pooled pixel, one-cycle pulse per result
//   pool_last_o               high with the final pooled pixel of a frame
//   frame_done_o              one-cycle pulse the cycle after pool_last_o
//   pool_cnt_o                pooled pixels emitted so far in the current frame
//
// Build option: define POOL_RELU_EN to treat input as two's complement and clamp
// negative pixels to zero before pooling (output = max(0, window max)).
module maxpool_2x2 #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cnn_valid_i,
  input  logic [DATA_W-1:0] cnn_data_i,
  output logic              pool_valid_o,
  output logic [DATA_W-1:0] pool_data_o,
  output logic              pool_last_o,
  output logic              frame_done_o,
  output logic [15:0]       pool_cnt_o
);

  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_D = IMG_W / 2;
  localparam int AW   = (LB_D > 1) ? $clog2(LB_D) : 1;

  generate
    if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_img_w
      $fatal(1, "maxpool_2x2: IMG_W must be even and >= 2");
    end
    if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_img_h
      $fatal(1, "maxpool_2x2: IMG_H must be even and >= 2");
    end
  endgenerate

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] linebuf [LB_D];

  logic [DATA_W-1:0] px;
  logic [AW-1:0]     lb_idx;
  logic [DATA_W-1:0] lb_rd;
  logic [DATA_W-1:0] max_hp;
  logic [DATA_W-1:0] win_max;
  logic              col_odd;
  logic              row_odd;
  logic              col_last;
  logic              row_last;
  logic              first_out;

  // Negative pixels are zeroed up front so hold, line buffer and compare all
  // see non-negative values and a plain unsigned max works.
  always_comb begin
`ifdef POOL_RELU_EN
    px = cnn_data_i[DATA_W-1] ? '0 : cnn_data_i;
`else
    px = cnn_data_i;
`endif
  end

  assign col_odd   = col[0];
  assign row_odd   = row[0];
  assign col_last  = (col == CW'(IMG_W - 1));
  assign row_last  = (row == RW'(IMG_H - 1));
  // The bottom-right beat of the top-left window produces the frame's first output.
  assign first_out = (row == RW'(1)) && (col == CW'(1));

  assign lb_idx  = AW'(col >> 1);
  assign lb_rd   = linebuf[lb_idx];
  assign max_hp  = (hold >= px) ? hold : px;
  assign win_max = (max_hp >= lb_rd) ? max_hp : lb_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      hold         <= '0;
      pool_valid_o <= 1'b0;
      pool_data_o  <= '0;
      pool_last_o  <= 1'b0;
      frame_done_o <= 1'b0;
      pool_cnt_o   <= '0;
    end else begin
      pool_valid_o <= 1'b0;
      pool_last_o  <= 1'b0;
      frame_done_o <= pool_last_o;
      if (cnn_valid_i) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end

        if (!col_odd) begin
          hold <= px;
        end else if (row_odd) begin
          pool_valid_o <= 1'b1;
          pool_data_o  <= win_max;
          pool_last_o  <= row_last && col_last;
          pool_cnt_o   <= first_out ? 16'd1 : pool_cnt_o + 16'd1;
        end
      end
    end
  end

  // Horizontal pair maxima of the even row, consumed by the odd row below it.
  // Contents are don't-care after reset because every slot is rewritten before use.
  always_ff @(posedge clk) begin
    if (!rst && cnn_valid_i && !row_odd && col_odd) begin
      linebuf[lb_idx] <= max_hp;
    end
  end

endmodule
